mcx_core: RTL

Parametrised successor to the MC9999 single-cycle microcontroller core. It adds the following over MC9999:
- configurable data width, program depth and simple-I/O port count;
- a run-time program load port;
- Shenzhen-style conditional execution via a +/- test flag;
- saturating arithmetic;
- tick-counted sleep with a visible busy state.

It sits in the board model alongside MC9999 instances, driven by the fast `clk` and a one-cycle `tick` pulse per big-clock step.

---
 rtl/mcx_core.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mcx_core.sv
// mcx_core: parametrised single-cycle microcontroller core with conditional
// execution, saturating arithmetic, tick-counted sleep and a loadable program store.
module mcx_core #(
    parameter int  DATA_W = 11,
    parameter int  PC_W   = 4,
    parameter int  NPORTS = 2,
    parameter int  LIMIT  = 999,
    localparam int IW     = 8 + 2 * DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run,
    input  logic                     tick,
    input  logic                     prog_we,
    input  logic [PC_W-1:0]          prog_addr,
    input  logic [IW-1:0]            prog_data,
    input  logic [NPORTS*DATA_W-1:0] p_in,
    output logic [NPORTS*DATA_W-1:0] p_out,
    output logic [DATA_W-1:0]        acc,
    output logic [PC_W-1:0]          pc,
    output logic                     busy
);
    localparam int WW = 2 * DATA_W;
    localparam logic signed [WW-1:0] SAT_HI = WW'(LIMIT);
    localparam logic signed [WW-1:0] SAT_LO = -SAT_HI;

    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_TEQ = 4'd6;
    localparam logic [3:0] OP_TGT = 4'd7;
    localparam logic [3:0] OP_TLT = 4'd8;
    localparam logic [3:0] OP_TCP = 4'd9;
    localparam logic [3:0] OP_JMP = 4'd10;
    localparam logic [3:0] OP_SLP = 4'd11;

    typedef enum logic [1:0] {FLAG_NONE, FLAG_PLUS, FLAG_MINUS} flag_t;
    typedef enum logic {ST_EXEC, ST_SLEEP} state_t;

    logic [IW-1:0]            prog_mem [2**PC_W];
    logic [IW-1:0]            instr;
    logic [3:0]               op;
    logic [1:0]               cond;
    logic                     a_imm;
    logic                     b_imm;
    logic [DATA_W-1:0]        a_field;
    logic [DATA_W-1:0]        b_field;
    logic signed [DATA_W-1:0] a_val;
    logic signed [DATA_W-1:0] b_val;
    logic signed [WW-1:0]     acc_w;
    logic signed [WW-1:0]     a_w;
    logic signed [DATA_W-1:0] mov_val;
    logic                     cond_ok;

    logic [DATA_W-1:0]        dat;
    flag_t                    flag;
    state_t                   state;
    logic [DATA_W-1:0]        sleep_cnt;

    logic [DATA_W-1:0]        acc_nx;
    logic [DATA_W-1:0]        dat_nx;
    logic [NPORTS*DATA_W-1:0] pout_nx;
    flag_t                    flag_nx;
    logic [PC_W-1:0]          pc_nx;
    logic                     sleep_go;

    // Clamp a wide intermediate result into the storable range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [WW-1:0] v);
        if (v > SAT_HI)
            sat = SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO)
            sat = SAT_LO[DATA_W-1:0];
        else
            sat = v[DATA_W-1:0];
    endfunction

    // Register-file read: acc, dat, then the port inputs; anything else reads zero.
    function automatic logic signed [DATA_W-1:0] read_src(
        input logic [2:0]               idx,
        input logic [DATA_W-1:0]        acc_v,
        input logic [DATA_W-1:0]        dat_v,
        input logic [NPORTS*DATA_W-1:0] pins
    );
        read_src = '0;
        if (idx == 3'd0)
            read_src = acc_v;
        else if (idx == 3'd1)
            read_src = dat_v;
        for (int k = 0; k < NPORTS; k++)
            if (idx == 3'(k + 2))
                read_src = pins[k*DATA_W +: DATA_W];
    endfunction

    // Program store: written on any edge with prog_we, never cleared by reset.
    always_ff @(posedge clk) begin
        if (prog_we)
            prog_mem[prog_addr] <= prog_data;
    end

    assign instr   = prog_mem[pc];
    assign op      = instr[IW-1 -: 4];
    assign cond    = instr[IW-5 -: 2];
    assign a_imm   = instr[IW-7];
    assign b_imm   = instr[IW-8];
    assign a_field = instr[2*DATA_W-1:DATA_W];
    assign b_field = instr[DATA_W-1:0];

    // Decode the current instruction into next-state values for every register.
    always_comb begin
        a_val    = a_imm ? a_field : read_src(a_field[2:0], acc, dat, p_in);
        b_val    = b_imm ? b_field : read_src(b_field[2:0], acc, dat, p_in);
        acc_w    = {{DATA_W{acc[DATA_W-1]}}, acc};
        a_w      = {{DATA_W{a_val[DATA_W-1]}}, a_val};
        mov_val  = sat(a_w);
        acc_nx   = acc;
        dat_nx   = dat;
        pout_nx  = p_out;
        flag_nx  = flag;
        pc_nx    = pc + 1'b1;
        sleep_go = 1'b0;
        case (cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = (flag == FLAG_PLUS);
            2'b10:   cond_ok = (flag == FLAG_MINUS);
            default: cond_ok = 1'b0;
        endcase
        if (cond_ok) begin
            case (op)
                OP_MOV: begin
                    if (b_field[2:0] == 3'd0)
                        acc_nx = mov_val;
                    else if (b_field[2:0] == 3'd1)
                        dat_nx = mov_val;
                    for (int k = 0; k < NPORTS; k++)
                        if (b_field[2:0] == 3'(k + 2))
                            pout_nx[k*DATA_W +: DATA_W] = mov_val;
                end
                OP_ADD:  acc_nx = sat(acc_w + a_w);
                OP_SUB:  acc_nx = sat(acc_w - a_w);
                OP_MUL:  acc_nx = sat(acc_w * a_w);
                OP_NOT:  acc_nx = (acc == '0) ? DATA_W'(100) : '0;
                OP_TEQ:  flag_nx = (a_val == b_val) ? FLAG_PLUS : FLAG_MINUS;
                OP_TGT:  flag_nx = (a_val > b_val) ? FLAG_PLUS : FLAG_MINUS;
                OP_TLT:  flag_nx = (a_val < b_val) ? FLAG_PLUS : FLAG_MINUS;
                OP_TCP:  flag_nx = (a_val > b_val) ? FLAG_PLUS :
                                   (a_val < b_val) ? FLAG_MINUS : FLAG_NONE;
                OP_JMP:  pc_nx = b_field[PC_W-1:0];
                OP_SLP:  sleep_go = !a_val[DATA_W-1] && (a_val != '0);
                default: ;
            endcase
        end
    end

    // Core state machine: execute one instruction per cycle or count down sleep ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= '0;
            acc       <= '0;
            dat       <= '0;
            p_out     <= '0;
            flag      <= FLAG_NONE;
            sleep_cnt <= '0;
            state     <= ST_EXEC;
            busy      <= 1'b0;
        end else if (run) begin
            case (state)
                ST_EXEC: begin
                    pc    <= pc_nx;
                    acc   <= acc_nx;
                    dat   <= dat_nx;
                    p_out <= pout_nx;
                    flag  <= flag_nx;
                    if (sleep_go) begin
                        sleep_cnt <= a_val;
                        state     <= ST_SLEEP;
                        busy      <= 1'b1;
                    end
                end
                ST_SLEEP: begin
                    if (tick) begin
                        if (sleep_cnt == DATA_W'(1)) begin
                            sleep_cnt <= '0;
                            state     <= ST_EXEC;
                            busy      <= 1'b0;
                        end else begin
                            sleep_cnt <= sleep_cnt - 1'b1;
                        end
                    end
                end
                default: state <= ST_EXEC;
            endcase
        end
    end
endmodule
